// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, stage-count helper and the pipeline stage record for pipelined_cla_adder.
package cla_pkg;
  localparam int CLA_GROUP_W = 4;
  localparam int CLA_MAX_W = 64;
  typedef struct packed {
    logic                 valid;
    logic [CLA_MAX_W-1:0] a_rem;
    logic [CLA_MAX_W-1:0] b_rem;
    logic [CLA_MAX_W-1:0] sum_done;
    logic                 carry;
    logic                 sub;
  } cla_stage_t;
  function automatic int cla_stages(input int width, input int chunk);
    return width / chunk;
  endfunction
endpackage

// File: rtl/cla_if.sv
// cla_if: operand/result stream with valid/ready on both sides; sub exists only with CLA_ADDSUB_EN.
interface cla_if #(parameter int WIDTH = 32);
  logic             in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CLA_ADDSUB_EN
  logic             sub;
`endif
  modport master (
`ifdef CLA_ADDSUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
`ifdef CLA_ADDSUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group (all carries from p/g and carry-in).
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] i_a,
  input  logic [CLA_GROUP_W-1:0] i_b,
  input  logic                   i_ci,
  output logic [CLA_GROUP_W-1:0] o_s,
  output logic                   o_co
);
  logic [CLA_GROUP_W-1:0] w_p, w_g;
  logic                   w_c1, w_c2, w_c3;
  assign w_p  = i_a ^ i_b;
  assign w_g  = i_a & i_b;
  assign w_c1 = w_g[0] | (w_p[0] & i_ci);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & i_ci);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & i_ci);
  assign o_co = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0]) | (&w_p & i_ci);
  assign o_s  = w_p ^ {w_c3, w_c2, w_c1, i_ci};
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: streaming WIDTH-bit adder resolving one CHUNK slice per pipeline stage.
// Define CLA_ADDSUB_EN to add the sub port (A - B when sub=1).
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic  clk,
  input logic  rst,
  cla_if.slave bus
);
  localparam int STAGES = cla_stages(WIDTH, CHUNK);
  localparam int GROUPS = CHUNK / CLA_GROUP_W;
  if (WIDTH % CHUNK != 0 || CHUNK % CLA_GROUP_W != 0 || WIDTH > CLA_MAX_W) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4, WIDTH <= 64");
  end
  cla_stage_t       r_st [STAGES];
  logic [STAGES:0]  w_rdy;
  logic             w_sub;
  cla_stage_t       w_o;
`ifdef CLA_ADDSUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif
  // A stage may load when empty or when everything downstream is moving.
  always_comb begin
    w_rdy[STAGES] = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) w_rdy[i] = !r_st[i].valid || w_rdy[i+1];
  end
  assign bus.in_ready = w_rdy[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    cla_stage_t       w_d;
    logic [CHUNK-1:0] w_a, w_b, w_s;
    if (k == 0) begin : g_in
      assign w_d = '{valid: bus.in_valid, a_rem: CLA_MAX_W'(bus.a), b_rem: CLA_MAX_W'(bus.b),
                     sum_done: '0, carry: w_sub | bus.cin, sub: w_sub};
    end else begin : g_link
      assign w_d = r_st[k-1];
    end
    assign w_a = w_d.a_rem[k*CHUNK +: CHUNK];
    assign w_b = w_d.b_rem[k*CHUNK +: CHUNK] ^ {CHUNK{w_d.sub}};
    for (genvar j = 0; j < GROUPS; j++) begin : g_grp
      logic w_ci, w_co;
      if (j == 0) begin : g_first
        assign w_ci = w_d.carry;
      end else begin : g_next
        assign w_ci = g_grp[j-1].w_co;
      end
      cla_group4 u_grp (
        .i_a  (w_a[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .i_b  (w_b[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .i_ci (w_ci),
        .o_s  (w_s[j*CLA_GROUP_W +: CLA_GROUP_W]),
        .o_co (w_co)
      );
    end
    always_ff @(posedge clk)
      if (rst && k == STAGES - 1) r_st[k] <= '0;
      else if (rst) r_st[k].valid <= 1'b0;
      else if (w_rdy[k]) begin
        r_st[k] <= w_d;
        r_st[k].sum_done[k*CHUNK +: CHUNK] <= w_s;
        r_st[k].carry <= g_grp[GROUPS-1].w_co;
      end
  end
  assign w_o           = r_st[STAGES-1];
  assign bus.out_valid = w_o.valid;
  assign bus.sum       = w_o.sum_done[WIDTH-1:0];
  assign bus.cout      = w_o.carry;
  // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
  assign bus.ovf       = w_o.a_rem[WIDTH-1] ^ w_o.b_rem[WIDTH-1] ^ w_o.sub ^ w_o.sum_done[WIDTH-1] ^ w_o.carry;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and streamed checks of pipelined_cla_adder against an arithmetic model.
module tb_pipelined_cla_adder;
  localparam int W = 32, C = 8, S = W / C;
  typedef struct {
    logic [W-1:0] sum;
    logic         cout, ovf;
    int           t;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  cla_if #(.WIDTH(W)) bus ();
  pipelined_cla_adder #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  exp_t         q[$];
  exp_t         m_e, pin;
  int           n_cmp = 0, n_bad = 0, cyc = 0, n_emit = 0, n_wait = 0, base;
  bit           lat_chk = 1'b0, prev_stall = 1'b0, prev_rst = 1'b0;
  logic [W+2:0] prev_out;
  logic [W-1:0] l_sum;
  logic         l_cout, l_ovf, w_sub_in;
`ifdef CLA_ADDSUB_EN
  assign w_sub_in = bus.sub;
`else
  assign w_sub_in = 1'b0;
`endif
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  // Reference: plain (W+1)-bit arithmetic; signed overflow when like-signed operands give an unlike-signed sum.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W:0]   r;
    logic [W-1:0] bb;
    exp_t         e;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
    e.sum = r[W-1:0];
    e.cout = r[W];
    e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    e.t = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_in_ready", bus.in_ready, 1);
    end
    prev_rst = rst;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {bus.out_valid, bus.sum, bus.cout, bus.ovf}, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        n_emit++;
        l_sum = bus.sum; l_cout = bus.cout; l_ovf = bus.ovf;
        if (q.size() == 0) chk("unexpected_emit", 1, 0);
        else begin
          m_e = q.pop_front();
          chk("result", {bus.sum, bus.cout, bus.ovf}, {m_e.sum, m_e.cout, m_e.ovf});
          if (lat_chk) chk("latency", cyc - m_e.t, S);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m_e = model(bus.a, bus.b, bus.cin, w_sub_in);
        m_e.t = cyc;
        q.push_back(m_e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_valid, bus.sum, bus.cout, bus.ovf};
    end
  end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
`ifdef CLA_ADDSUB_EN
    bus.sub = sub;
`endif
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (i == 0) n_wait++;
      if (i > 200) begin chk("in_ready_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
`ifdef CLA_ADDSUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {bus.out_valid, bus.sum, bus.cout, bus.ovf}, '0);
    @(posedge clk); #1; rst = 1'b0;
    pin = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("pin_wrap", {pin.sum, pin.cout, pin.ovf}, {32'h0, 1'b1, 1'b0});
    pin = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("pin_ovf", {pin.sum, pin.cout, pin.ovf}, {32'h8000_0000, 1'b0, 1'b1});
    pin = model(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    chk("pin_cin", {pin.sum, pin.cout, pin.ovf}, {32'h2345_678A, 1'b0, 1'b0});
    pin = model(32'h5, 32'h7, 1'b1, 1'b1);
    chk("pin_sub", {pin.sum, pin.cout, pin.ovf}, {32'hFFFF_FFFE, 1'b0, 1'b0});
    pin = model(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    chk("pin_sub_ovf", {pin.sum, pin.cout, pin.ovf}, {32'h7FFF_FFFF, 1'b1, 1'b1});
    // Directed adds with the pipe otherwise empty; latency checked on every emit.
    lat_chk = 1'b1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); drain();
    chk("t1_wrap", {l_sum, l_cout, l_ovf}, {32'h0, 1'b1, 1'b0});
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0); drain();
    chk("t2_ovf", {l_sum, l_cout, l_ovf}, {32'h8000_0000, 1'b0, 1'b1});
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0); drain();
    chk("t2_cin", {l_sum, l_cout}, {32'h2345_678A, 1'b0});
    // Back-to-back stream: never back-pressured, one result per cycle.
    base = n_emit; n_wait = 0;
    for (int i = 0; i < 200; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    drain();
    chk("t3_no_backpressure", n_wait, 0);
    chk("t3_count", n_emit - base, 200);
    // Output stalled: four fill the pipe, the fifth is held off until release.
    lat_chk = 1'b0; base = n_emit;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'h0101_0101 * i, 32'hF0F0_F0F0, 1'(i), 1'b0);
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h2152_4111; bus.cin = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_full_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1; bus.out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    drain();
    chk("t4_count", n_emit - base, 6);
    chk("t4_last", {l_sum, l_cout, l_ovf}, {32'h0000_0001, 1'b1, 1'b1});
    // Reset with three in flight: nothing stale may emerge.
    base = n_emit;
    send(32'h1, 32'h2, 1'b0, 1'b0);
    send(32'h3, 32'h4, 1'b0, 1'b0);
    send(32'h5, 32'h6, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_flushed", n_emit - base, 0);
    lat_chk = 1'b1;
    send(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0); drain();
    chk("t5_after_rst", {l_sum, l_cout, l_ovf}, {32'h0002_0000, 1'b0, 1'b0});
`ifdef CLA_ADDSUB_EN
    send(32'h5, 32'h7, 1'b0, 1'b1); drain();
    chk("t6_sub", {l_sum, l_cout, l_ovf}, {32'hFFFF_FFFE, 1'b0, 1'b0});
    send(32'h5, 32'h7, 1'b1, 1'b1); drain();
    chk("t6_sub_cin_ignored", {l_sum, l_cout, l_ovf}, {32'hFFFF_FFFE, 1'b0, 1'b0});
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1); drain();
    chk("t6_sub_ovf", {l_sum, l_ovf}, {32'h7FFF_FFFF, 1'b1});
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
